// File: rtl/exception_unit_if.sv
// Bundle between the commit stage / COP0 and the exception arbiter.
// The pipeline side uses master; the arbiter uses slave.
interface exception_unit_if;
    logic        commit_valid;
    logic        commit_stall;
    logic [31:0] commit_pc;
    logic        commit_in_ds;
    logic        if_adel;
    logic        id_ri;
    logic        id_syscall;
    logic        id_break;
    logic        ex_ov;
    logic        mem_adel;
    logic        mem_ades;
    logic        commit_eret;
    logic [31:0] mem_addr;
    logic [5:0]  hw_int;
    logic [31:0] cp0_status;
    logic [31:0] cp0_cause;
    logic [31:0] cp0_epc;
    logic        exp_en;
    logic        exp_badvaddr_en;
    logic        exp_bd;
    logic [31:0] exp_badvaddr;
    logic [31:0] exp_epc;
    logic [4:0]  exp_code;
    logic        eret_clr;
    logic        flush;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    modport master (
        output commit_valid, commit_stall, commit_pc, commit_in_ds,
               if_adel, id_ri, id_syscall, id_break, ex_ov, mem_adel, mem_ades,
               commit_eret, mem_addr, hw_int, cp0_status, cp0_cause, cp0_epc,
        input  exp_en, exp_badvaddr_en, exp_bd, exp_badvaddr, exp_epc, exp_code,
               eret_clr, flush, redirect_valid, redirect_pc
    );

    modport slave (
        input  commit_valid, commit_stall, commit_pc, commit_in_ds,
               if_adel, id_ri, id_syscall, id_break, ex_ov, mem_adel, mem_ades,
               commit_eret, mem_addr, hw_int, cp0_status, cp0_cause, cp0_epc,
        output exp_en, exp_badvaddr_en, exp_bd, exp_badvaddr, exp_epc, exp_code,
               eret_clr, flush, redirect_valid, redirect_pc
    );
endinterface

// File: rtl/exception_unit.sv
// Commit-stage exception arbiter: prioritises per-stage faults and interrupts,
// emits the one-cycle COP0 strobe, then flushes and redirects fetch.
module exception_unit #(
    parameter logic [31:0] EXC_VECTOR   = 32'hBFC0_0380,
    parameter int          FLUSH_CYCLES = 2
) (
    input  logic clk,
    input  logic rst,
    exception_unit_if.slave bus
);
    localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

    typedef enum logic {IDLE, FLUSH} state_t;

    state_t      state_reg, state_next;
    logic [3:0]  cnt_reg, cnt_next;
    logic [5:0]  int_meta_reg, int_sync_reg;

    logic        exp_en_reg, exp_en_next;
    logic        exp_badvaddr_en_reg, exp_badvaddr_en_next;
    logic        exp_bd_reg, exp_bd_next;
    logic [31:0] exp_badvaddr_reg, exp_badvaddr_next;
    logic [31:0] exp_epc_reg, exp_epc_next;
    logic [4:0]  exp_code_reg, exp_code_next;
    logic        eret_clr_reg, eret_clr_next;
    logic        redirect_valid_reg, redirect_valid_next;
    logic [31:0] redirect_pc_reg, redirect_pc_next;

    logic        int_req, evaluate, exc_hit, exc_bv_en;
    logic [4:0]  exc_code;
    logic [31:0] exc_bv;

    // Two-flop synchroniser per interrupt line.
    generate
        for (genvar gi = 0; gi < 6; gi++) begin : g_int_sync
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    int_meta_reg[gi] <= 1'b0;
                    int_sync_reg[gi] <= 1'b0;
                end else begin
                    int_meta_reg[gi] <= bus.hw_int[gi];
                    int_sync_reg[gi] <= int_meta_reg[gi];
                end
            end
        end
    endgenerate

    assign int_req  = bus.cp0_status[0] && !bus.cp0_status[1] &&
                      (({int_sync_reg, bus.cp0_cause[9:8]} & bus.cp0_status[15:8]) != 8'd0);
    assign evaluate = (state_reg == IDLE) && bus.commit_valid && !bus.commit_stall;

    always_comb begin
        exc_hit   = 1'b1;
        exc_code  = 5'd0;
        exc_bv_en = 1'b0;
        exc_bv    = 32'd0;
        if (int_req) begin
            exc_code = 5'd0;
        end else if (bus.if_adel) begin
            exc_code  = 5'd4;
            exc_bv_en = 1'b1;
            exc_bv    = bus.commit_pc;
        end else if (bus.id_ri) begin
            exc_code = 5'd10;
        end else if (bus.id_syscall) begin
            exc_code = 5'd8;
        end else if (bus.id_break) begin
            exc_code = 5'd9;
        end else if (bus.ex_ov) begin
            exc_code = 5'd12;
        end else if (bus.mem_adel) begin
            exc_code  = 5'd4;
            exc_bv_en = 1'b1;
            exc_bv    = bus.mem_addr;
        end else if (bus.mem_ades) begin
            exc_code  = 5'd5;
            exc_bv_en = 1'b1;
            exc_bv    = bus.mem_addr;
        end else begin
            exc_hit = 1'b0;
        end
    end

    always_comb begin
        state_next           = state_reg;
        cnt_next             = cnt_reg;
        exp_en_next          = 1'b0;
        eret_clr_next        = 1'b0;
        redirect_valid_next  = 1'b0;
        exp_badvaddr_en_next = exp_badvaddr_en_reg;
        exp_bd_next          = exp_bd_reg;
        exp_badvaddr_next    = exp_badvaddr_reg;
        exp_epc_next         = exp_epc_reg;
        exp_code_next        = exp_code_reg;
        redirect_pc_next     = redirect_pc_reg;
        unique case (state_reg)
            IDLE: begin
                if (evaluate && (exc_hit || bus.commit_eret)) begin
                    state_next          = FLUSH;
                    cnt_next            = FLUSH_LOAD;
                    redirect_valid_next = 1'b1;
                    if (exc_hit) begin
                        exp_en_next          = 1'b1;
                        exp_code_next        = exc_code;
                        exp_bd_next          = bus.commit_in_ds;
                        exp_epc_next         = bus.commit_in_ds ? bus.commit_pc - 32'd4 : bus.commit_pc;
                        exp_badvaddr_en_next = exc_bv_en;
                        exp_badvaddr_next    = exc_bv;
                        redirect_pc_next     = EXC_VECTOR;
                    end else begin
                        eret_clr_next    = 1'b1;
                        redirect_pc_next = bus.cp0_epc;
                    end
                end
            end
            FLUSH: begin
                if (cnt_reg == 4'd0) state_next = IDLE;
                else                 cnt_next   = cnt_reg - 4'd1;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg           <= IDLE;
            cnt_reg             <= 4'd0;
            exp_en_reg          <= 1'b0;
            exp_badvaddr_en_reg <= 1'b0;
            exp_bd_reg          <= 1'b0;
            exp_badvaddr_reg    <= 32'd0;
            exp_epc_reg         <= 32'd0;
            exp_code_reg        <= 5'd0;
            eret_clr_reg        <= 1'b0;
            redirect_valid_reg  <= 1'b0;
            redirect_pc_reg     <= 32'd0;
        end else begin
            state_reg           <= state_next;
            cnt_reg             <= cnt_next;
            exp_en_reg          <= exp_en_next;
            exp_badvaddr_en_reg <= exp_badvaddr_en_next;
            exp_bd_reg          <= exp_bd_next;
            exp_badvaddr_reg    <= exp_badvaddr_next;
            exp_epc_reg         <= exp_epc_next;
            exp_code_reg        <= exp_code_next;
            eret_clr_reg        <= eret_clr_next;
            redirect_valid_reg  <= redirect_valid_next;
            redirect_pc_reg     <= redirect_pc_next;
        end
    end

    // flush decodes the state register so an asynchronous reset drops it at once.
    assign bus.flush           = (state_reg == FLUSH);
    assign bus.exp_en          = exp_en_reg;
    assign bus.exp_badvaddr_en = exp_badvaddr_en_reg;
    assign bus.exp_bd          = exp_bd_reg;
    assign bus.exp_badvaddr    = exp_badvaddr_reg;
    assign bus.exp_epc         = exp_epc_reg;
    assign bus.exp_code        = exp_code_reg;
    assign bus.eret_clr        = eret_clr_reg;
    assign bus.redirect_valid  = redirect_valid_reg;
    assign bus.redirect_pc     = redirect_pc_reg;

    logic unused_bits;
    assign unused_bits = ^{bus.cp0_status[31:16], bus.cp0_status[7:2],
                           bus.cp0_cause[31:10], bus.cp0_cause[7:0]};
endmodule

// File: tb/tb_exception_unit.sv
// Directed-vector bench for exception_unit; inputs change and outputs are
// sampled on the falling edge.
module tb_exception_unit;
    localparam logic [31:0] VEC = 32'hBFC0_0380;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    exception_unit_if bus();

    exception_unit #(.EXC_VECTOR(VEC), .FLUSH_CYCLES(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", tag, actual, expected);
        end
    endtask

    task automatic clear_inputs();
        bus.commit_valid = 1'b0;
        bus.commit_stall = 1'b0;
        bus.commit_pc    = 32'd0;
        bus.commit_in_ds = 1'b0;
        bus.if_adel      = 1'b0;
        bus.id_ri        = 1'b0;
        bus.id_syscall   = 1'b0;
        bus.id_break     = 1'b0;
        bus.ex_ov        = 1'b0;
        bus.mem_adel     = 1'b0;
        bus.mem_ades     = 1'b0;
        bus.commit_eret  = 1'b0;
        bus.mem_addr     = 32'd0;
        bus.hw_int       = 6'd0;
        bus.cp0_status   = 32'd0;
        bus.cp0_cause    = 32'd0;
        bus.cp0_epc      = 32'd0;
    endtask

    // Clear the commit inputs (leaving COP0/interrupt state) and ride out the flush.
    task automatic drop_commit_and_drain();
        bus.commit_valid = 1'b0;
        bus.commit_in_ds = 1'b0;
        bus.if_adel = 1'b0; bus.id_ri = 1'b0; bus.id_syscall = 1'b0; bus.id_break = 1'b0;
        bus.ex_ov = 1'b0; bus.mem_adel = 1'b0; bus.mem_ades = 1'b0; bus.commit_eret = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        clear_inputs();
        bus.commit_valid = 1'b1;
        bus.id_syscall   = 1'b1;
        bus.commit_pc    = 32'h0000_1000;
        bus.hw_int       = 6'h3F;
        bus.commit_eret  = 1'b1;
        bus.cp0_epc      = 32'h1234_5678;

        // Reset held with inputs active
        repeat (3) @(negedge clk);
        $display("txn reset-with-inputs");
        check("rst_exp_en", bus.exp_en, 0);
        check("rst_flush", bus.flush, 0);
        check("rst_redirect_valid", bus.redirect_valid, 0);
        check("rst_redirect_pc", bus.redirect_pc, 0);
        check("rst_eret_clr", bus.eret_clr, 0);
        check("rst_exp_epc", bus.exp_epc, 0);
        check("rst_exp_code", bus.exp_code, 0);

        // Syscall right after reset release
        bus.hw_int = 6'd0; bus.commit_eret = 1'b0; bus.cp0_epc = 32'd0;
        rst = 1'b1;
        @(negedge clk);
        $display("txn syscall pc=00001000");
        check("sys_exp_en", bus.exp_en, 1);
        check("sys_code", bus.exp_code, 8);
        check("sys_epc", bus.exp_epc, 32'h0000_1000);
        check("sys_bd", bus.exp_bd, 0);
        check("sys_bv_en", bus.exp_badvaddr_en, 0);
        check("sys_rv", bus.redirect_valid, 1);
        check("sys_rpc", bus.redirect_pc, VEC);
        check("sys_flush1", bus.flush, 1);
        clear_inputs();
        @(negedge clk);
        check("sys_exp_en_pulse", bus.exp_en, 0);
        check("sys_rv_pulse", bus.redirect_valid, 0);
        check("sys_flush2", bus.flush, 1);
        check("sys_code_hold", bus.exp_code, 8);
        @(negedge clk);
        check("sys_flush3", bus.flush, 0);

        // Store address error in a delay slot at PC 0
        bus.commit_valid = 1'b1; bus.commit_in_ds = 1'b1; bus.mem_ades = 1'b1;
        bus.commit_pc = 32'h0; bus.mem_addr = 32'h8000_0003;
        @(negedge clk);
        $display("txn ades in delay slot");
        check("ades_code", bus.exp_code, 5);
        check("ades_epc", bus.exp_epc, 32'hFFFF_FFFC);
        check("ades_bd", bus.exp_bd, 1);
        check("ades_bv_en", bus.exp_badvaddr_en, 1);
        check("ades_bv", bus.exp_badvaddr, 32'h8000_0003);
        drop_commit_and_drain();

        // Fetch AdEL beats RI and Ov
        bus.commit_valid = 1'b1; bus.if_adel = 1'b1; bus.id_ri = 1'b1; bus.ex_ov = 1'b1;
        bus.commit_pc = 32'hBFC0_0001;
        @(negedge clk);
        $display("txn fetch adel + ri + ov");
        check("fadel_code", bus.exp_code, 4);
        check("fadel_bv", bus.exp_badvaddr, 32'hBFC0_0001);
        check("fadel_bv_en", bus.exp_badvaddr_en, 1);
        drop_commit_and_drain();

        // Same plus software interrupt pending: Int wins
        bus.cp0_status = 32'h0000_0101; bus.cp0_cause = 32'h0000_0100;
        bus.commit_valid = 1'b1; bus.if_adel = 1'b1; bus.id_ri = 1'b1; bus.ex_ov = 1'b1;
        bus.commit_pc = 32'hBFC0_0001;
        @(negedge clk);
        $display("txn interrupt beats fetch adel");
        check("int_code", bus.exp_code, 0);
        check("int_bv_en", bus.exp_badvaddr_en, 0);
        check("int_bv", bus.exp_badvaddr, 0);
        check("int_epc", bus.exp_epc, 32'hBFC0_0001);
        drop_commit_and_drain();
        bus.cp0_status = 32'd0; bus.cp0_cause = 32'd0;

        // Hardware interrupt through the synchroniser
        bus.cp0_status = 32'h0000_0401; bus.hw_int = 6'b000001;
        bus.commit_valid = 1'b1; bus.commit_pc = 32'h0000_2000;
        @(negedge clk);
        $display("txn hw_int[0] synchroniser");
        check("hwi_lat1", bus.exp_en, 0);
        @(negedge clk);
        check("hwi_lat2", bus.exp_en, 0);
        check("hwi_lat2_flush", bus.flush, 0);
        @(negedge clk);
        check("hwi_exp_en", bus.exp_en, 1);
        check("hwi_code", bus.exp_code, 0);
        check("hwi_epc", bus.exp_epc, 32'h0000_2000);
        drop_commit_and_drain();

        // EXL set masks the same interrupt
        bus.cp0_status = 32'h0000_0403;
        bus.commit_valid = 1'b1; bus.commit_pc = 32'h0000_3000;
        @(negedge clk);
        $display("txn hw_int with EXL=1");
        check("exl_exp_en", bus.exp_en, 0);
        check("exl_flush", bus.flush, 0);
        clear_inputs();
        @(negedge clk);

        // ERET alone
        bus.commit_valid = 1'b1; bus.commit_eret = 1'b1; bus.cp0_epc = 32'h0040_0020;
        @(negedge clk);
        $display("txn eret");
        check("eret_clr", bus.eret_clr, 1);
        check("eret_rv", bus.redirect_valid, 1);
        check("eret_rpc", bus.redirect_pc, 32'h0040_0020);
        check("eret_exp_en", bus.exp_en, 0);
        check("eret_flush", bus.flush, 1);
        clear_inputs();
        @(negedge clk);
        check("eret_clr_pulse", bus.eret_clr, 0);
        @(negedge clk);

        // ERET with overflow: exception wins
        bus.commit_valid = 1'b1; bus.commit_eret = 1'b1; bus.ex_ov = 1'b1;
        bus.cp0_epc = 32'h0040_0020; bus.commit_pc = 32'h0000_4000;
        @(negedge clk);
        $display("txn eret + ov");
        check("eov_code", bus.exp_code, 12);
        check("eov_exp_en", bus.exp_en, 1);
        check("eov_eret_clr", bus.eret_clr, 0);
        check("eov_rpc", bus.redirect_pc, VEC);
        clear_inputs();
        repeat (2) @(negedge clk);

        // Stalled commit is not evaluated
        bus.commit_valid = 1'b1; bus.commit_stall = 1'b1; bus.id_break = 1'b1;
        repeat (2) @(negedge clk);
        $display("txn stalled break");
        check("stall_exp_en", bus.exp_en, 0);
        check("stall_flush", bus.flush, 0);
        clear_inputs();

        // Commit during FLUSH is ignored
        bus.commit_valid = 1'b1; bus.id_syscall = 1'b1; bus.commit_pc = 32'h0000_5000;
        @(negedge clk);
        $display("txn commit during flush");
        bus.id_syscall = 1'b0; bus.id_break = 1'b1;
        @(negedge clk);
        check("dflush_exp_en", bus.exp_en, 0);
        @(negedge clk);
        clear_inputs();
        check("dflush_after_exp_en", bus.exp_en, 0);
        check("dflush_after_flush", bus.flush, 0);
        check("dflush_code_hold", bus.exp_code, 8);

        // Reset asserted in the middle of FLUSH
        bus.commit_valid = 1'b1; bus.id_syscall = 1'b1; bus.commit_pc = 32'h0000_6000;
        @(negedge clk);
        $display("txn reset mid-flush");
        clear_inputs();
        check("rmid_flush_before", bus.flush, 1);
        #2 rst = 1'b0;
        #1;
        check("rmid_flush_async", bus.flush, 0);
        check("rmid_rpc", bus.redirect_pc, 0);
        check("rmid_exp_en", bus.exp_en, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rmid_flush_after", bus.flush, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/exception_unit.md
# exception_unit

Commit-stage exception arbiter feeding the COP0 register file. Collects per-stage exception flags for the instruction leaving MEM, synchronises hardware interrupt lines, and picks the highest-priority cause. Produces the one-cycle `exp_*` strobe that COP0 captures, plus pipeline flush and PC-redirect control, including ERET return.

## Interface
Parameters:
- `EXC_VECTOR`, 32'hBFC0_0380, exception handler entry PC.
- `FLUSH_CYCLES`, 2, flush length in cycles (legal 1..15).

Ports:
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  reset; asynchronous, active-low (0 = reset).
- `commit_valid`  in  1  instruction present at commit.
- `commit_stall`  in  1  commit stalled; no evaluation while high.
- `commit_pc`  in  32  PC of committing instruction.
- `commit_in_ds`  in  1  committing instruction is in a branch delay slot.
- `if_adel`, `id_ri`, `id_syscall`, `id_break`, `ex_ov`, `mem_adel`, `mem_ades`  in  1 each  exception flags carried with the instruction.
- `commit_eret`  in  1  committing instruction is ERET.
- `mem_addr`  in  32  data address for `mem_adel`/`mem_ades`.
- `hw_int`  in  6  asynchronous hardware interrupt lines.
- `cp0_status`, `cp0_cause`, `cp0_epc`  in  32 each  current COP0 Status/Cause/EPC.
- `exp_en`, `exp_badvaddr_en`, `exp_bd`  out  1 each  to COP0.
- `exp_badvaddr`, `exp_epc`  out  32 each  to COP0.
- `exp_code`  out  5  to COP0.
- `eret_clr`  out  1  one-cycle pulse: clear Status.EXL.
- `flush`  out  1  kill all pre-commit stages.
- `redirect_valid`  out  1  one-cycle fetch redirect.
- `redirect_pc`  out  32  redirect target.

## Operation
- `hw_int` passes through a 2-flop synchroniser per bit; `int_sync[5:0]` is the second flop.
- Interrupt request: `IE=Status[0]=1`, `EXL=Status[1]=0`, and `({int_sync, cp0_cause[9:8]} & cp0_status[15:8]) != 0`.
- Evaluation occurs only in IDLE with `commit_valid=1` and `commit_stall=0`.
- Priority, highest first, with code:
  - Int 0
  - fetch AdEL 4
  - RI 10
  - Sys 8
  - Bp 9
  - Ov 12
  - data AdEL 4
  - AdES 5
- Any exception beats `commit_eret` in the same cycle.
- `exp_epc` = `commit_in_ds ? commit_pc - 4 : commit_pc` (32-bit modulo; 0 → 32'hFFFF_FFFC). `exp_bd` = `commit_in_ds`.
- `exp_badvaddr_en`/`exp_badvaddr`:
  - fetch AdEL: 1 / `commit_pc`.
  - data AdEL or AdES: 1 / `mem_addr`.
  - all other causes: 0 / 0.
- ERET with no exception: `eret_clr` pulse; `redirect_pc = cp0_epc`, sampled in the evaluation cycle. `exp_en` stays 0.
- FSM:
  - IDLE → FLUSH when an exception or ERET is accepted. Loads the output registers and sets `cnt = FLUSH_CYCLES-1`.
  - FLUSH: `flush=1`; decrement `cnt`; → IDLE when `cnt==0`.
  - All commit inputs are ignored in FLUSH.
- Interrupts are level-sampled, never latched. A request arriving during FLUSH is evaluated against the first valid commit after returning to IDLE.

## Timing
- Reset (async, `rst=0`): FSM IDLE, synchroniser 0, `cnt` 0, every output 0 (`redirect_pc`, `exp_*` buses included).
- Reset mid-FLUSH aborts the sequence immediately.
- Detection in cycle T (registered at edge ending T), then in cycle T+1:
  - `exp_en` (or `eret_clr`) and `redirect_valid` high for exactly one cycle.
  - COP0 captures at the edge ending T+1.
- `flush` is high for cycles T+1 .. T+FLUSH_CYCLES. Next evaluation is possible in cycle T+FLUSH_CYCLES+1.
- `exp_*` data and `redirect_pc` hold their values until the next accepted event.
- Interrupt latency: an edge on `hw_int` is visible in `int_sync` 2 clocks later.

## Test plan
- Reset with inputs active → all outputs 0; release, `commit_valid=1`, `id_syscall=1`, `commit_pc=0x0000_1000` → T+1: `exp_en=1`, code 8, `exp_epc=0x1000`, `exp_bd=0`, `redirect_pc=EXC_VECTOR`; `flush` high exactly 2 cycles.
- `commit_in_ds=1`, `mem_ades=1`, `commit_pc=0x0000_0000`, `mem_addr=0x8000_0003` → code 5, `exp_epc=0xFFFF_FFFC`, `exp_bd=1`, `exp_badvaddr_en=1`, `exp_badvaddr=0x8000_0003`.
- `if_adel`, `id_ri`, `ex_ov` together with `commit_pc=0xBFC0_0001` → code 4, `exp_badvaddr=0xBFC0_0001`; same plus a pending interrupt → code 0, `exp_badvaddr_en=0`.
- Status=0x0000_0401, `hw_int[0]` raised → no Int before 2 clocks; next eligible commit gives code 0. Repeat with Status=0x0000_0403 (EXL=1) → no exception.
- `commit_eret=1`, `cp0_epc=0x0040_0020` → `eret_clr` pulse, `redirect_pc=0x0040_0020`, `exp_en=0`. ERET together with `ex_ov` → code 12, no `eret_clr`.
- `commit_stall=1` with `id_break` → nothing. Assert `rst=0` mid-FLUSH → `flush` drops asynchronously. Commit during FLUSH is ignored.
